// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared state encoding and iteration constants for the iterative multiplier
package seq_multiplier_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operation request / result bundle between the issuer and the multiplier
interface seq_multiplier_if;

  logic                                        start;
  logic                                        is_signed;
  logic [seq_multiplier_pkg::MUL_WIDTH-1:0]    a;
  logic [seq_multiplier_pkg::MUL_WIDTH-1:0]    b;
  logic                                        busy;
  logic                                        done;
  logic [2*seq_multiplier_pkg::MUL_WIDTH-1:0]  product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_multiplier_adder.sv
// rtl/seq_multiplier_adder.sv - 32-bit ripple adder with carry-out and signed overflow
module seq_multiplier_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] f_o,
  output logic        cout_o,
  output logic        of_o
);

  assign {cout_o, f_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, cin_i};
  assign of_o          = (a_i[31] == b_i[31]) && (f_o[31] != a_i[31]);

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 iterative 32x32->64 multiplier, unsigned shift-add or signed Booth
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seq_multiplier_if.slave   mul
);

  if (WIDTH != MUL_WIDTH) begin : g_width_check
    $error("seq_multiplier: WIDTH must be 32 to match the datapath adder");
  end

  localparam logic [4:0] CNT_LAST = 5'(MUL_ITERS - 1);

  mul_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] m_q;
  logic [31:0] p_hi_q;
  logic [31:0] q_q;
  logic        q1_q;
  logic        sgn_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_f;
  logic        add_cout;
  logic        add_of;
  logic        shift_in;
  logic        accept;
  logic        zero_op;

  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == ST_RUN) begin
      if (!sgn_q) begin
        if (q_q[0]) add_b = m_q;
      end else begin
        case ({q_q[0], q1_q})
          2'b01:   add_b = m_q;
          2'b10: begin
            add_b   = ~m_q;
            add_cin = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
    end
  end

  seq_multiplier_adder u_adder_32 (
    .a_i    (p_hi_q),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .f_o    (add_f),
    .cout_o (add_cout),
    .of_o   (add_of)
  );

  // Signed mode recovers the true sign even when the partial sum overflowed (M = 0x80000000).
  assign shift_in = sgn_q ? (add_f[31] ^ add_of) : add_cout;
  assign accept   = mul.start && (state_q != ST_RUN);
  assign zero_op  = EARLY_ZERO && ((mul.a == '0) || (mul.b == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_hi_q  <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          p_hi_q <= {shift_in, add_f[31:1]};
          q_q    <= {add_f[0], q_q[31:1]};
          q1_q   <= q_q[0];
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            m_q    <= mul.a;
            q_q    <= zero_op ? '0 : mul.b;
            p_hi_q <= '0;
            q1_q   <= 1'b0;
            cnt_q  <= '0;
            sgn_q  <= mul.is_signed;
            if (zero_op) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign mul.busy    = busy_q;
  assign mul.done    = done_q;
  assign mul.product = {p_hi_q, q_q};

endmodule
